// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the supported operand width range.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage : serial_arith_pkg

// File: rtl/fa_cell.sv
// Single full-adder cell; the only arithmetic element in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and majority carry of the three input bits
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : fa_cell

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor. Operands are loaded on an input handshake,
// consumed LSB-first through one full-adder cell over WIDTH cycles, and the
// result with carry and signed overflow is offered on an output handshake.
// Subtraction is A + ~B + 1: B is inverted at load and the carry starts at 1.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic             fa_sum;
  logic             fa_cout;
  logic             last_step;
  logic [WIDTH-1:0] result_shift;

  fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign result_shift = fa_sum;
    end else begin : g_res_wn
      assign result_shift = {fa_sum, result_q[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next-state: load in IDLE, one bit per cycle in SHIFT, hold otherwise
  always_comb begin
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d = op_a;
          b_sh_d = sub ? ~op_b : op_b;
          c_d    = sub;
          cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        c_d      = fa_cout;
        result_d = result_shift;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          // c_q here is the carry into the MSB, fa_cout the carry out of it
          carry_out_d = fa_cout;
          overflow_d  = c_q ^ fa_cout;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8 and WIDTH=1 with a result
// scoreboard per instance.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8, carry8, ovf8;
  logic [7:0] op_a8, op_b8, result8;

  // WIDTH=1 instance
  logic       in_valid1, in_ready1, sub1, out_valid1, out_ready1, carry1, ovf1;
  logic [0:0] op_a1, op_b1, result1;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry_out(carry8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .carry_out(carry1), .overflow(ovf1)
  );

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for WIDTH=8: plain integer add of A and B' plus carry-in
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t       e;
    logic [7:0] bp;
    logic [8:0] full;
    logic [7:0] low;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {8'd0, s};
    low  = {1'b0, a[6:0]} + {1'b0, bp[6:0]} + {7'd0, s};
    e.r  = full[7:0];
    e.c  = full[8];
    e.o  = low[7] ^ full[8];
    return e;
  endfunction

  // Present operands and complete the accepting edge; push the expectation
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input exp_t e, input string tag);
    check({tag, " in_ready"}, 32'(in_ready8), 32'd1);
    op_a8 = a; op_b8 = b; sub8 = s; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    q8.push_back(e);
  endtask

  // Wait for out_valid (bounded) and check it arrives exactly WIDTH cycles later
  task automatic wait_done8(input string tag);
    int k = 0;
    while (!out_valid8 && k < 40) begin
      tick();
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'd8);
  endtask

  task automatic compare8(input string tag);
    exp_t e;
    if (q8.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'(q8.size()), 32'd1);
    end else begin
      e = q8.pop_front();
      check({tag, " result"}, 32'(result8), 32'(e.r));
      check({tag, " carry"}, 32'(carry8), 32'(e.c));
      check({tag, " ovf"}, 32'(ovf8), 32'(e.o));
    end
  endtask

  task automatic retire8(input string tag);
    out_ready8 = 1'b1;
    compare8(tag);
    tick();
    out_ready8 = 1'b0;
    check({tag, " out_valid low"}, 32'(out_valid8), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready8), 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] er, input logic ec, input logic eo, input string tag);
    exp_t e;
    e.r = er; e.c = ec; e.o = eo;
    start8(a, b, s, e, tag);
    wait_done8(tag);
    retire8(tag);
  endtask

  // WIDTH=1 operation; expectation from the full-adder truth table
  task automatic run1(input logic a, input logic b, input logic s, input string tag);
    exp_t e;
    logic bp;
    int   k = 0;
    bp  = s ? ~b : b;
    e.r = {7'd0, a ^ bp ^ s};
    e.c = (a & bp) | (a & s) | (bp & s);
    e.o = s ^ e.c;
    check({tag, " in_ready"}, 32'(in_ready1), 32'd1);
    op_a1 = a; op_b1 = b; sub1 = s; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    q1.push_back(e);
    while (!out_valid1 && k < 20) begin
      tick();
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'd1);
    out_ready1 = 1'b1;
    if (q1.size() != 0) begin
      e = q1.pop_front();
      check({tag, " result"}, 32'(result1), 32'(e.r[0]));
      check({tag, " carry"}, 32'(carry1), 32'(e.c));
      check({tag, " ovf"}, 32'(ovf1), 32'(e.o));
    end
    tick();
    out_ready1 = 1'b0;
    check({tag, " idle"}, 32'(in_ready1), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [7:0] ra, rb;
    logic       rs;
    logic [7:0] held_r;
    logic       held_c, held_o;

    rst_n = 1'b0;
    in_valid8 = 0; sub8 = 0; out_ready8 = 0; op_a8 = '0; op_b8 = '0;
    in_valid1 = 0; sub1 = 0; out_ready1 = 0; op_a1 = '0; op_b1 = '0;
    tick();
    tick();

    // Reset values
    check("rst result", 32'(result8), 32'd0);
    check("rst carry", 32'(carry8), 32'd0);
    check("rst ovf", 32'(ovf8), 32'd0);
    check("rst out_valid", 32'(out_valid8), 32'd0);
    check("rst in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases
    run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add 0F+01");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+01");
    run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub 05-07");
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub 80-01");

    // Random operations against the integer model
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      e  = model8(ra, rb, rs);
      run8(ra, rb, rs, e.r, e.c, e.o, $sformatf("rand%0d", i));
    end

    // Backpressure: stall 5 cycles in DONE while offering a new operand
    e.r = 8'hC4; e.c = 1'b0; e.o = 1'b1;
    start8(8'h64, 8'h60, 1'b0, e, "stall");
    wait_done8("stall");
    held_r = result8; held_c = carry8; held_o = ovf8;
    op_a8 = 8'h01; op_b8 = 8'h02; sub8 = 1'b0; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d result", i), 32'(result8), 32'(held_r));
      check($sformatf("stall%0d carry", i), 32'(carry8), 32'(held_c));
      check($sformatf("stall%0d ovf", i), 32'(ovf8), 32'(held_o));
      check($sformatf("stall%0d in_ready", i), 32'(in_ready8), 32'd0);
      check($sformatf("stall%0d out_valid", i), 32'(out_valid8), 32'd1);
    end

    // Retire with in_valid still high: new op is taken one cycle later in IDLE
    op_a8 = 8'h20; op_b8 = 8'h03; sub8 = 1'b0;
    out_ready8 = 1'b1;
    compare8("stall");
    tick();
    out_ready8 = 1'b0;
    check("retire out_valid", 32'(out_valid8), 32'd0);
    check("retire in_ready", 32'(in_ready8), 32'd1);
    tick();
    in_valid8 = 1'b0;
    e.r = 8'h23; e.c = 1'b0; e.o = 1'b0;
    q8.push_back(e);
    check("overlap accepted", 32'(in_ready8), 32'd0);
    wait_done8("overlap");
    retire8("overlap");

    // Reset during the 4th SHIFT cycle aborts the operation asynchronously
    op_a8 = 8'hAA; op_b8 = 8'h55; sub8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid8), 32'd0);
    check("abort result", 32'(result8), 32'd0);
    check("abort in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "post-reset 12+34");

    // WIDTH=1: full truth table of (a, b, sub)
    for (int i = 0; i < 8; i++) begin
      run1(i[2], i[1], i[0], $sformatf("w1 a%0d b%0d s%0d", i[2], i[1], i[0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_addsub
